// File: rtl/mystic_mem_pkg.sv
// Shared definitions for the main-memory arbiter and the UART boot loader.
package mystic_mem_pkg;

  // Memory ownership mode
  typedef enum logic {
    S_RUN  = 1'b0,
    S_LOAD = 1'b1
  } mode_e;

  // Requester identifiers used for round-robin bookkeeping
  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

  localparam int unsigned MEM_WORDS   = 1 << 16;
  localparam logic [31:0] BOOT_HEADER = 32'hABCD1234;

endpackage

// File: rtl/mystic_rr_arb2.sv
// Two-way round-robin arbiter between instruction fetch and data ports.
// Grants are combinational; the last grantee is remembered so that a
// simultaneous request goes to the other port.
module mystic_rr_arb2
  import mystic_mem_pkg::*;
(
  input  logic clk_i,
  input  logic rstn_i,
  input  logic en_i,
  input  logic req_if_i,
  input  logic req_d_i,
  output logic gnt_if_o,
  output logic gnt_d_o
);

  req_id_e last_q;

  // Pick a winner; on conflict favour the port that did not win last
  always_comb begin
    gnt_if_o = 1'b0;
    gnt_d_o  = 1'b0;
    if (en_i) begin
      if (req_if_i && req_d_i) begin
        if (last_q == REQ_IF) gnt_d_o  = 1'b1;
        else                  gnt_if_o = 1'b1;
      end else begin
        gnt_if_o = req_if_i;
        gnt_d_o  = req_d_i;
      end
    end
  end

  // Remember the most recent grantee; held while nothing is granted
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)       last_q <= REQ_IF;
    else if (gnt_if_o) last_q <= REQ_IF;
    else if (gnt_d_o)  last_q <= REQ_D;
  end

endmodule

// File: rtl/mystic_mem_arbiter.sv
// Single-port main memory arbiter: boot loader byte writes while the core
// is held off, otherwise round-robin between core fetch and data ports.
// Read responses come back one cycle after the grant with no backpressure.
module mystic_mem_arbiter
  import mystic_mem_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                ld_disable_core_n_i,
  input  logic                ld_we_i,
  input  logic [ADDR_W-1:0]   ld_addr_i,
  input  logic [7:0]          ld_data_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                mem_en_o,
  output logic [DATA_W/8-1:0] mem_we_o,
  output logic [ADDR_W-3:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                ld_drop_o
);

  mode_e state_q, state_d;
  logic  run;
  logic  rsp_if_p1, rsp_d_p1, rsp_rd_p1;
  logic  drop_q;
  logic  unused_addr_bits;

  // Word-aligned core accesses: the byte offset bits carry no meaning here
  assign unused_addr_bits = ^{if_addr_i[1:0], d_addr_i[1:0]};

  assign run = (state_q == S_RUN);

  // Mode register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_RUN;
    else         state_q <= state_d;
  end

  // Next mode follows the loader's core-disable line
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (!ld_disable_core_n_i) state_d = S_LOAD;
      S_LOAD:  if (ld_disable_core_n_i)  state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  mystic_rr_arb2 u_arb (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .en_i     (run),
    .req_if_i (if_req_i),
    .req_d_i  (d_req_i),
    .gnt_if_o (if_gnt_o),
    .gnt_d_o  (d_gnt_o)
  );

  // Memory port steering: loader byte lanes in S_LOAD, granted core port in S_RUN
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (!run) begin
      if (ld_we_i) begin
        mem_en_o    = 1'b1;
        mem_addr_o  = ld_addr_i[ADDR_W-1:2];
        mem_wdata_o = {4{ld_data_i}};
        mem_we_o    = 4'b0001 << ld_addr_i[1:0];
      end
    end else if (if_gnt_o) begin
      mem_en_o   = 1'b1;
      mem_addr_o = if_addr_i[ADDR_W-1:2];
    end else if (d_gnt_o) begin
      mem_en_o    = 1'b1;
      mem_addr_o  = d_addr_i[ADDR_W-1:2];
      mem_we_o    = d_we_i ? d_be_i : '0;
      mem_wdata_o = d_wdata_i;
    end
  end

  // Stage p1: tag the grantee so the response lands on the right port
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rsp_if_p1 <= 1'b0;
      rsp_d_p1  <= 1'b0;
      rsp_rd_p1 <= 1'b0;
    end else begin
      rsp_if_p1 <= if_gnt_o;
      rsp_d_p1  <= d_gnt_o;
      rsp_rd_p1 <= d_gnt_o && !d_we_i;
    end
  end

  // Sticky record of loader writes that arrived while the core owned memory
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)               drop_q <= 1'b0;
    else if (run && ld_we_i)   drop_q <= 1'b1;
  end

  assign ld_drop_o   = drop_q;
  assign if_rvalid_o = rsp_if_p1;
  assign if_rdata_o  = rsp_if_p1 ? mem_rdata_i : '0;
  assign d_rvalid_o  = rsp_d_p1;
  assign d_rdata_o   = (rsp_d_p1 && rsp_rd_p1) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mystic_mem_arbiter.sv
// Scoreboard bench for mystic_mem_arbiter: stimulus pushes expected
// responses, a negedge monitor pops and compares them.
module tb_mystic_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        ld_disable_core_n_i;
  logic        ld_we_i;
  logic [17:0] ld_addr_i;
  logic [7:0]  ld_data_i;
  logic        if_req_i;
  logic [17:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i, d_we_i;
  logic [3:0]  d_be_i;
  logic [17:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_gnt_o, d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        mem_en_o;
  logic [3:0]  mem_we_o;
  logic [15:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        ld_drop_o;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  logic [15:0] rd_addr_q = '0;

  always #5 clk_i = ~clk_i;

  mystic_mem_arbiter dut (
    .clk_i               (clk_i),
    .rstn_i              (rstn_i),
    .ld_disable_core_n_i (ld_disable_core_n_i),
    .ld_we_i             (ld_we_i),
    .ld_addr_i           (ld_addr_i),
    .ld_data_i           (ld_data_i),
    .if_req_i            (if_req_i),
    .if_addr_i           (if_addr_i),
    .if_gnt_o            (if_gnt_o),
    .if_rvalid_o         (if_rvalid_o),
    .if_rdata_o          (if_rdata_o),
    .d_req_i             (d_req_i),
    .d_we_i              (d_we_i),
    .d_be_i              (d_be_i),
    .d_addr_i            (d_addr_i),
    .d_wdata_i           (d_wdata_i),
    .d_gnt_o             (d_gnt_o),
    .d_rvalid_o          (d_rvalid_o),
    .d_rdata_o           (d_rdata_o),
    .mem_en_o            (mem_en_o),
    .mem_we_o            (mem_we_o),
    .mem_addr_o          (mem_addr_o),
    .mem_wdata_o         (mem_wdata_o),
    .mem_rdata_i         (mem_rdata_i),
    .ld_drop_o           (ld_drop_o)
  );

  // Memory stand-in: a read returns 0xC0DE in the top half and the word address below
  always @(posedge clk_i) begin
    if (mem_en_o && mem_we_o == 4'b0000) rd_addr_q <= mem_addr_o;
  end
  assign mem_rdata_i = {16'hC0DE, rd_addr_q};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle();
    ld_we_i   = 1'b0; ld_addr_i = '0; ld_data_i = '0;
    if_req_i  = 1'b0; if_addr_i = '0;
    d_req_i   = 1'b0; d_we_i    = 1'b0; d_be_i = '0; d_addr_i = '0; d_wdata_i = '0;
  endtask

  task automatic push(input bit is_d, input logic [31:0] rdata);
    rsp_t e;
    e.is_d  = is_d;
    e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  // Response monitor
  always @(negedge clk_i) begin
    rsp_t e;
    if (if_rvalid_o || d_rvalid_o) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rvalid: if_rvalid=%0b d_rvalid=%0b expected none", if_rvalid_o, d_rvalid_o);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_if_rvalid", {31'b0, if_rvalid_o}, {31'b0, !e.is_d});
        chk("rsp_d_rvalid",  {31'b0, d_rvalid_o},  {31'b0, e.is_d});
        if (e.is_d) chk("d_rdata", d_rdata_o, e.rdata);
        else        chk("if_rdata", if_rdata_o, e.rdata);
      end
    end
    if (!if_rvalid_o) chk("if_rdata_idle", if_rdata_o, 32'h0);
    if (!d_rvalid_o)  chk("d_rdata_idle",  d_rdata_o,  32'h0);
  end

  initial begin
    rstn_i = 1'b0;
    ld_disable_core_n_i = 1'b1;
    idle();
    cyc(); cyc();
    // reset state
    chk("rst_if_gnt",    {31'b0, if_gnt_o},    32'h0);
    chk("rst_d_gnt",     {31'b0, d_gnt_o},     32'h0);
    chk("rst_mem_en",    {31'b0, mem_en_o},    32'h0);
    chk("rst_mem_we",    {28'b0, mem_we_o},    32'h0);
    chk("rst_if_rvalid", {31'b0, if_rvalid_o}, 32'h0);
    chk("rst_d_rvalid",  {31'b0, d_rvalid_o},  32'h0);
    chk("rst_ld_drop",   {31'b0, ld_drop_o},   32'h0);
    rstn_i = 1'b1;

    // single IF read
    cyc();
    if_req_i = 1'b1; if_addr_i = 18'h00010;
    settle();
    chk("if1_gnt",      {31'b0, if_gnt_o},  32'h1);
    chk("if1_d_gnt",    {31'b0, d_gnt_o},   32'h0);
    chk("if1_mem_en",   {31'b0, mem_en_o},  32'h1);
    chk("if1_mem_addr", {16'b0, mem_addr_o}, 32'h0004);
    chk("if1_mem_we",   {28'b0, mem_we_o},  32'h0);
    push(1'b0, 32'hC0DE0004);

    // both requesting for 4 cycles: D, IF, D, IF
    for (int i = 0; i < 4; i++) begin
      cyc();
      if_req_i = 1'b1; if_addr_i = 18'h00020;
      d_req_i  = 1'b1; d_we_i = 1'b0; d_addr_i = 18'h00100;
      settle();
      chk("rr_if_gnt", {31'b0, if_gnt_o}, (i % 2 == 1) ? 32'h1 : 32'h0);
      chk("rr_d_gnt",  {31'b0, d_gnt_o},  (i % 2 == 0) ? 32'h1 : 32'h0);
      chk("rr_mem_addr", {16'b0, mem_addr_o}, (i % 2 == 0) ? 32'h0040 : 32'h0008);
      if (i % 2 == 0) push(1'b1, 32'hC0DE0040);
      else            push(1'b0, 32'hC0DE0008);
    end

    // D read in the cycle the loader takes over
    cyc();
    idle();
    d_req_i = 1'b1; d_addr_i = 18'h00200;
    ld_disable_core_n_i = 1'b0;
    settle();
    chk("pre_load_d_gnt",    {31'b0, d_gnt_o},    32'h1);
    chk("pre_load_mem_addr", {16'b0, mem_addr_o}, 32'h0080);
    push(1'b1, 32'hC0DE0080);

    // loader byte writes; core requests held and ignored
    cyc();
    if_req_i = 1'b1; if_addr_i = 18'h00030;
    ld_we_i = 1'b1; ld_addr_i = 18'h00007; ld_data_i = 8'h5A;
    settle();
    chk("ld1_if_gnt",    {31'b0, if_gnt_o},   32'h0);
    chk("ld1_d_gnt",     {31'b0, d_gnt_o},    32'h0);
    chk("ld1_mem_en",    {31'b0, mem_en_o},   32'h1);
    chk("ld1_mem_we",    {28'b0, mem_we_o},   32'h8);
    chk("ld1_mem_addr",  {16'b0, mem_addr_o}, 32'h0001);
    chk("ld1_mem_wdata", mem_wdata_o,         32'h5A5A5A5A);
    cyc();
    ld_addr_i = 18'h00004; ld_data_i = 8'h11;
    settle();
    chk("ld2_mem_we",    {28'b0, mem_we_o},   32'h1);
    chk("ld2_mem_wdata", mem_wdata_o,         32'h11111111);
    chk("ld2_d_gnt",     {31'b0, d_gnt_o},    32'h0);
    cyc();
    ld_we_i = 1'b0;
    settle();
    chk("ld_idle_mem_en", {31'b0, mem_en_o}, 32'h0);
    chk("ld_idle_if_gnt", {31'b0, if_gnt_o}, 32'h0);
    chk("ld_ld_drop",     {31'b0, ld_drop_o}, 32'h0);

    // release: transition cycle still in S_LOAD
    cyc();
    ld_disable_core_n_i = 1'b1;
    settle();
    chk("exit_if_gnt", {31'b0, if_gnt_o}, 32'h0);
    chk("exit_d_gnt",  {31'b0, d_gnt_o},  32'h0);

    // back in S_RUN: last grant was D, so IF wins
    cyc();
    settle();
    chk("run_if_gnt",   {31'b0, if_gnt_o},   32'h1);
    chk("run_d_gnt",    {31'b0, d_gnt_o},    32'h0);
    chk("run_mem_addr", {16'b0, mem_addr_o}, 32'h000C);
    push(1'b0, 32'hC0DE000C);
    cyc();
    if_req_i = 1'b0;
    settle();
    chk("run_d2_gnt", {31'b0, d_gnt_o}, 32'h1);
    push(1'b1, 32'hC0DE0080);

    // D partial write at top of memory
    cyc();
    idle();
    d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b0110; d_addr_i = 18'h3FFFC; d_wdata_i = 32'hDEADBEEF;
    settle();
    chk("dw_gnt",       {31'b0, d_gnt_o},    32'h1);
    chk("dw_mem_addr",  {16'b0, mem_addr_o}, 32'hFFFF);
    chk("dw_mem_we",    {28'b0, mem_we_o},   32'h6);
    chk("dw_mem_wdata", mem_wdata_o,         32'hDEADBEEF);
    push(1'b1, 32'h0);

    // D write with no byte enables: still granted and acked
    cyc();
    d_be_i = 4'b0000; d_addr_i = 18'h00040;
    settle();
    chk("dw0_gnt",    {31'b0, d_gnt_o},  32'h1);
    chk("dw0_mem_en", {31'b0, mem_en_o}, 32'h1);
    chk("dw0_mem_we", {28'b0, mem_we_o}, 32'h0);
    push(1'b1, 32'h0);

    // loader write while running is dropped and flagged
    cyc();
    idle();
    ld_we_i = 1'b1; ld_addr_i = 18'h00005; ld_data_i = 8'h77;
    settle();
    chk("drop_mem_en", {31'b0, mem_en_o}, 32'h0);
    chk("drop_mem_we", {28'b0, mem_we_o}, 32'h0);
    cyc();
    ld_we_i = 1'b0;
    settle();
    chk("drop_set", {31'b0, ld_drop_o}, 32'h1);

    // back-to-back IF grants
    cyc();
    if_req_i = 1'b1; if_addr_i = 18'h00100;
    settle();
    chk("b2b0_if_gnt", {31'b0, if_gnt_o}, 32'h1);
    push(1'b0, 32'hC0DE0040);
    cyc();
    if_addr_i = 18'h00104;
    settle();
    chk("b2b1_if_gnt", {31'b0, if_gnt_o}, 32'h1);
    chk("b2b1_mem_addr", {16'b0, mem_addr_o}, 32'h0041);
    push(1'b0, 32'hC0DE0041);
    chk("drop_sticky", {31'b0, ld_drop_o}, 32'h1);

    // reset with a response pending: it must vanish
    cyc();
    if_addr_i = 18'h00200;
    settle();
    chk("rstmid_if_gnt", {31'b0, if_gnt_o}, 32'h1);
    #2;
    rstn_i = 1'b0;
    cyc();
    idle();
    settle();
    chk("rstmid_if_rvalid", {31'b0, if_rvalid_o}, 32'h0);
    chk("rstmid_ld_drop",   {31'b0, ld_drop_o},   32'h0);
    cyc();
    rstn_i = 1'b1;

    // after reset: last grant is IF again, so D wins a conflict
    cyc();
    if_req_i = 1'b1; if_addr_i = 18'h00010;
    d_req_i  = 1'b1; d_addr_i  = 18'h00008;
    settle();
    chk("post_rst_d_gnt",  {31'b0, d_gnt_o},  32'h1);
    chk("post_rst_if_gnt", {31'b0, if_gnt_o}, 32'h0);
    push(1'b1, 32'hC0DE0002);

    cyc();
    idle();
    cyc(); cyc(); cyc();
    chk("scoreboard_drained", exp_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
